// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared constants and FSM encoding for the instruction-fetch sequencer
package fetch_ctrl_pkg;

  localparam logic [31:0] PC_pcDefault = 32'h0000_3000;
  localparam int          IM_ROM_SIZE  = 4096;

  localparam int FETCH_BUF_W = 64;

  typedef enum logic {
    FETCH_RUN   = 1'b0,
    FETCH_FAULT = 1'b1
  } fetch_state_e;

  function automatic logic [FETCH_BUF_W-1:0] pack_entry(input logic [31:0] pc,
                                                         input logic [31:0] instr);
    return {pc, instr};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - 2-entry FIFO of {pc, instr} words between the ROM and decode
module fetch_buf
  import fetch_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [FETCH_BUF_W-1:0] push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [1:0]             count,
  output logic [FETCH_BUF_W-1:0] head_data
);

  logic [FETCH_BUF_W-1:0] mem [2];
  logic                   rd_ptr;
  logic                   wr_ptr;
  logic [1:0]             cnt;

  // Storage is cleared on reset so the head reads as zero while empty after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign count     = cnt;
  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer: PC, redirect, 2-deep buffer to decode
// Optional illegal-PC trap enabled by defining FETCH_BOUNDS_CHECK_EN.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = PC_pcDefault,
  parameter int          ROM_WORDS = IM_ROM_SIZE
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fault
);

  if (ROM_WORDS < 1 || (ROM_WORDS & (ROM_WORDS - 1)) != 0) begin : g_bad_rom_words
    $error("fetch_ctrl: ROM_WORDS must be a power of two");
  end

  logic [31:0]            pc_q;
  logic [31:0]            pc_d;
  logic [1:0]             count;
  logic [FETCH_BUF_W-1:0] head_data;
  logic                   push;
  logic                   pop;
  logic                   slot_free;
  logic                   legal;
  logic                   run;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign slot_free = (count != 2'd2) || pop;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [32:0] ROM_SPAN = 33'(ROM_WORDS) << 2;

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  pc_off;

  assign pc_off = pc_q - PC_RESET;
  assign legal  = (pc_q[1:0] == 2'b00) && (pc_q >= PC_RESET) && ({1'b0, pc_off} < ROM_SPAN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Trap only when an illegal PC would otherwise have been pushed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_RUN: begin
        if (!redirect_valid && !legal && slot_free) begin
          state_d = FETCH_FAULT;
        end
      end
      FETCH_FAULT: begin
        if (redirect_valid) begin
          state_d = FETCH_RUN;
        end
      end
      default: state_d = FETCH_RUN;
    endcase
  end

  assign run   = (state_q == FETCH_RUN);
  assign fault = (state_q == FETCH_FAULT);
`else
  assign legal = 1'b1;
  assign run   = 1'b1;
  assign fault = 1'b0;
`endif

  assign push = run && !redirect_valid && legal && slot_free;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (push) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  // A redirect flushes everything; a same-cycle pop has already been seen by decode.
  fetch_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (pack_entry(pc_q, im_instr)),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head_data (head_data)
  );

  assign im_addr   = pc_q;
  assign out_pc    = head_data[63:32];
  assign out_instr = head_data[31:0];

endmodule
